bin2bcd_seq: RTL and testbench

//  - Sequential double-dabble converter: unsigned binary -> four BCD digits.
//  - Sits directly upstream of the 4-digit seven-segment time-mux stage.
//  - bcd3..bcd0 drive hex3..hex0 of that stage, so a counter or sensor value shows in decimal.
//  - Start/ready/done handshake; one bit processed per clock; results held until the next conversion.

---
 rtl/bin2bcd_pkg.sv | 7 +
 rtl/bcd_add3.sv | 10 +
 rtl/bin2bcd_seq.sv | 98 +++++++++
 tb/tb_bin2bcd_seq.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;
    typedef enum logic [1:0] {IDLE, OP, DONE} bin2bcd_state_t;
    localparam int NDIG    = 4;
    localparam int MAX_DEC = 9999;
    typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, returns d+3 when d>=5, else d.
// Ports: d - working BCD digit in; q - corrected digit out.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, unsigned BIN_W-bit binary to four BCD digits.
// Ports: clk, reset (async, active high), start/bin request, ready (idle), done (1-cycle pulse),
//        bcd3..bcd0 (thousands..units), ovf (captured bin > 9999).
// Build option: define BIN2BCD_SAT_EN to saturate the digits to 9999 on overflow;
//        otherwise the digits show bin mod 10000.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             ready,
    output logic             done,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0,
    output logic             ovf
);
    localparam int NW = $clog2(BIN_W);

    bin2bcd_state_t   state_q, state_d;
    logic [NW-1:0]    n_q, n_d;
    logic [BIN_W-1:0] sr_q, sr_d, sr_sh;
    logic [15:0]      work_q, work_d, work_sh, adj;
    logic [15:0]      dig_q, dig_d;
    logic             ovf_q, ovf_d;
    logic             ovf_nx_q, ovf_nx_d;

    for (genvar i = 0; i < NDIG; i++) begin : g_add3
        bcd_add3 u_add3 (.d(work_q[4*i +: 4]), .q(adj[4*i +: 4]));
    end

    // Corrected digits and the binary shift register move left as one word;
    // the bit leaving the thousands digit is dropped (mod-10000 truncation).
    assign {work_sh, sr_sh} = {adj[14:0], sr_q, 1'b0};

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        sr_d     = sr_q;
        work_d   = work_q;
        dig_d    = dig_q;
        ovf_d    = ovf_q;
        ovf_nx_d = ovf_nx_q;
        if (state_q == IDLE && start) begin
            sr_d     = bin;
            work_d   = '0;
            n_d      = NW'(BIN_W - 1);
            ovf_nx_d = 32'(bin) > MAX_DEC;
            state_d  = OP;
        end else if (state_q == OP) begin
            sr_d   = sr_sh;
            work_d = work_sh;
            if (n_q == '0) begin
`ifdef BIN2BCD_SAT_EN
                dig_d = ovf_nx_q ? 16'h9999 : work_sh;
`else
                dig_d = work_sh;
`endif
                ovf_d   = ovf_nx_q;
                state_d = DONE;
            end else begin
                n_d = n_q - NW'(1);
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            n_q      <= '0;
            sr_q     <= '0;
            work_q   <= '0;
            dig_q    <= '0;
            ovf_q    <= 1'b0;
            ovf_nx_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            sr_q     <= sr_d;
            work_q   <= work_d;
            dig_q    <= dig_d;
            ovf_q    <= ovf_d;
            ovf_nx_q <= ovf_nx_d;
        end
    end

    assign ready = state_q == IDLE;
    assign done  = state_q == DONE;
    assign {bcd3, bcd2, bcd1, bcd0} = dig_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq with directed vectors.
module tb_bin2bcd_seq;
    localparam int BIN_W = 14;

    typedef struct {
        logic [15:0] dig;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    logic             ready, done, ovf;
    logic [3:0]       bcd3, bcd2, bcd1, bcd0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t e;
    int   k1, k2, k3, kx;

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .ready(ready), .done(done),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Waits (bounded) for ready, then presents one request; returns the acceptance cycle.
    task automatic convert(input logic [BIN_W-1:0] v, input logic [15:0] ed, input logic eo,
                           input bit hold, input bit push, output int k);
        int t = 0;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        if (!hold) start = 1'b0;
        if (push) sbq.push_back('{dig: ed, ovf: eo, cyc: k + BIN_W});
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, {16'd0, e.dig});
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        convert(14'd0, 16'h0000, 1'b0, 0, 1, kx);
        convert(14'd1234, 16'h1234, 1'b0, 0, 1, kx);
        convert(14'd9999, 16'h9999, 1'b0, 0, 1, kx);
`ifdef BIN2BCD_SAT_EN
        convert(14'd10000, 16'h9999, 1'b1, 0, 1, kx);
`else
        convert(14'd10000, 16'h0000, 1'b1, 0, 1, kx);
`endif
        convert(14'd1234, 16'h1234, 1'b0, 0, 1, kx);
        repeat (3) @(posedge clk);
        #1;
        bin   = 14'd42;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        convert(14'd42, 16'h0042, 1'b0, 0, 1, kx);
`ifdef BIN2BCD_SAT_EN
        convert(14'd16383, 16'h9999, 1'b1, 0, 1, kx);
`else
        convert(14'd16383, 16'h6383, 1'b1, 0, 1, kx);
`endif
        drain();

        convert(14'd1234, 16'h0000, 1'b0, 0, 0, kx);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        convert(14'd500, 16'h0500, 1'b0, 0, 1, kx);
        drain();

        convert(14'd1, 16'h0001, 1'b0, 1, 1, k1);
        convert(14'd2, 16'h0002, 1'b0, 1, 1, k2);
        convert(14'd3, 16'h0003, 1'b0, 0, 1, k3);
        chk("b2b_gap1", 32'(k2 - k1), 32'd16);
        chk("b2b_gap2", 32'(k3 - k2), 32'd16);
        drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
